// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider-sharing arbiter.
// Optional feature macro used by the top: DIV_ARB_DBZ_BYPASS_EN.
package div_arb_pkg;

  localparam int unsigned DIV_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Every bit of a divide-by-zero quotient is set (all-ones of width W)
  localparam logic DBZ_QUO_BIT = 1'b1;

  // Width of a requester index; at least one bit so N=1 still has a port
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above i_ptr
// (wrapping modulo N) wins. Returns one-hot grant, its index and an any flag.
module rr_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic [PW:0] w_pos;

  // Scan offsets 0..N-1 from the pointer; the first asserted request wins
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < int'(N); k++) begin
      w_pos = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_pos >= (PW+1)'(N)) w_pos = w_pos - (PW+1)'(N);
      if (!o_any && i_req[w_pos[PW-1:0]]) begin
        o_any                   = 1'b1;
        o_grant[w_pos[PW-1:0]]  = 1'b1;
        o_idx                   = w_pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one start/finish iterative divider among N requesters.
// Optional macro DIV_ARB_DBZ_BYPASS_EN: a zero divisor is answered locally
// (quotient all ones, remainder = dividend, rsp_dbz=1) without using the divider.
module div_share_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = DIV_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   rsp_valid,
  input  logic [N-1:0]   rsp_ready,
  output logic [W-1:0]   rsp_quo,
  output logic [W-1:0]   rsp_rem,
  output logic           rsp_dbz,
  output logic           div_start,
  output logic [W-1:0]   div_a,
  output logic [W-1:0]   div_b,
  input  logic [W-1:0]   div_quo,
  input  logic [W-1:0]   div_rem,
  input  logic           div_finish,
  output logic           busy
);

  localparam int unsigned PW = idx_w(N);

  state_t        r_state, w_next;
  logic [PW-1:0] r_ptr, r_gidx, w_gidx, w_ptr_nxt;
  logic [N-1:0]  w_grant, w_rsp_oh;
  logic          w_any, w_fin_rise, r_fin_q;
  logic [W-1:0]  r_div_a, r_div_b, r_quo, r_rem, w_sel_a, w_sel_b;

  rr_arbiter #(.N(N), .PW(PW)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  // Operand mux for the requester the arbiter picked this cycle
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (w_gidx == PW'(i)) begin
        w_sel_a = req_a[i*W +: W];
        w_sel_b = req_b[i*W +: W];
      end
    end
  end

  // One-hot decode of the stored grant for the response valid
  always_comb begin
    w_rsp_oh = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (r_gidx == PW'(i)) w_rsp_oh[i] = 1'b1;
    end
  end

  assign w_ptr_nxt  = (w_gidx == PW'(N-1)) ? '0 : w_gidx + 1'b1;
  // A finish that is already high when we look is not a completion
  assign w_fin_rise = div_finish & ~r_fin_q;

  assign req_ready = (r_state == IDLE) ? w_grant : '0;
  assign rsp_valid = (r_state == RESP) ? w_rsp_oh : '0;
  assign div_start = (r_state == ISSUE);
  assign busy      = (r_state != IDLE);
  assign div_a     = r_div_a;
  assign div_b     = r_div_b;
  assign rsp_quo   = r_quo;
  assign rsp_rem   = r_rem;

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_any) begin
`ifdef DIV_ARB_DBZ_BYPASS_EN
          w_next = (w_sel_b == '0) ? RESP : ISSUE;
`else
          w_next = ISSUE;
`endif
        end
      end
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_fin_rise) w_next = RESP;
      RESP:    if (rsp_ready[r_gidx]) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Grant bookkeeping, operand capture, finish edge history and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_div_a <= '0;
      r_div_b <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_fin_q <= 1'b1;
    end else begin
      if (r_state == ISSUE || r_state == WAIT) r_fin_q <= div_finish;
      if (r_state == IDLE && w_any) begin
        r_gidx  <= w_gidx;
        r_ptr   <= w_ptr_nxt;
        r_div_a <= w_sel_a;
        r_div_b <= w_sel_b;
`ifdef DIV_ARB_DBZ_BYPASS_EN
        if (w_sel_b == '0) begin
          r_quo <= {W{DBZ_QUO_BIT}};
          r_rem <= w_sel_a;
        end
`endif
      end
      if (r_state == WAIT && w_fin_rise) begin
        r_quo <= div_quo;
        r_rem <= div_rem;
      end
    end
  end

`ifdef DIV_ARB_DBZ_BYPASS_EN
  logic r_dbz;

  // Flag marks a locally answered divide-by-zero; cleared for every other accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_dbz <= 1'b0;
    else if (r_state == IDLE && w_any) r_dbz <= (w_sel_b == '0);
  end

  assign rsp_dbz = r_dbz;
`else
  assign rsp_dbz = 1'b0;
`endif

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a behavioural start/finish divider.
module tb_div_share_arbiter;

  localparam int N = 4;
  localparam int W = 32;
`ifdef DIV_ARB_DBZ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [W-1:0]   rsp_quo, rsp_rem, div_a, div_b;
  logic [W-1:0]   div_quo = '0, div_rem = '0;
  logic           rsp_dbz, div_start, busy;
  logic           div_finish = 1'b0;
  int             n_tests = 0, n_fail = 0, n_starts = 0;

  logic [W-1:0]   m_a = '0, m_b = '0;
  int             m_cnt = 0;

  div_share_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quo(rsp_quo), .rsp_rem(rsp_rem), .rsp_dbz(rsp_dbz),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_quo(div_quo), .div_rem(div_rem), .div_finish(div_finish),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Iterative divider stand-in: 6 cycles, finish held high until next start
  always @(posedge clk) begin
    if (div_start) begin
      m_a        <= div_a;
      m_b        <= div_b;
      m_cnt      <= 6;
      div_finish <= 1'b0;
      n_starts   <= n_starts + 1;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        div_finish <= 1'b1;
        div_quo    <= (m_b == '0) ? '1  : m_a / m_b;
        div_rem    <= (m_b == '0) ? m_a : m_a % m_b;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int cnt = 0;
    while (req_ready == '0 && cnt < 50) begin step(); cnt++; end
    chk({tag, "_ready_timeout"}, 32'(cnt < 50), 32'd1);
  endtask

  task automatic wait_rsp(input string tag, output int cycles, output int fin_at);
    int cnt = 0;
    fin_at = -1;
    while (rsp_valid == '0 && cnt < 100) begin
      if (div_finish && fin_at < 0) fin_at = cnt;
      step();
      cnt++;
    end
    cycles = cnt;
    chk({tag, "_rsp_timeout"}, 32'(cnt < 100), 32'd1);
  endtask

  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er,
                       input bit edbz, input bit bypass, input string tag);
    logic [N-1:0] oh;
    int s0, cyc, fin_at;
    oh = 4'b0001 << idx;
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_valid = oh;
    #1;
    wait_ready(tag);
    chk({tag, "_grant"}, 32'(req_ready), 32'(oh));
    s0 = n_starts;
    step();
    req_valid = '0;
    #1;
    if (!bypass) begin
      chk({tag, "_start"}, 32'(div_start), 32'd1);
      chk({tag, "_div_a"}, div_a, a);
      chk({tag, "_div_b"}, div_b, b);
      step();
      chk({tag, "_start_1cyc"}, 32'(div_start), 32'd0);
    end else begin
      chk({tag, "_no_start"}, 32'(div_start), 32'd0);
    end
    wait_rsp(tag, cyc, fin_at);
    if (!bypass) chk({tag, "_latency"}, 32'(cyc - fin_at), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(oh));
    chk({tag, "_quo"}, rsp_quo, eq);
    chk({tag, "_rem"}, rsp_rem, er);
    chk({tag, "_dbz"}, 32'(rsp_dbz), 32'(edbz));
    chk({tag, "_nstart"}, 32'(n_starts - s0), bypass ? 32'd0 : 32'd1);
    rsp_ready = oh;
    step();
    rsp_ready = '0;
    chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [N-1:0] oh;
    logic [31:0]  tq [4];
    logic [31:0]  tr [4];
    int cyc, fin_at;

    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(div_start), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_quo", rsp_quo, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Round robin with every requester held valid from ptr=0
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 32'(100 + 10*i);
      req_b[i*W +: W] = 32'(3 + i);
    end
    tq = '{32'd33, 32'd27, 32'd24, 32'd21};
    tr = '{32'd1,  32'd2,  32'd0,  32'd4};
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      wait_ready($sformatf("rr%0d", k));
      chk($sformatf("rr%0d_grant", k), 32'(req_ready), 32'(oh));
      step();
      chk($sformatf("rr%0d_no_ready", k), 32'(req_ready), 32'd0);
      wait_rsp($sformatf("rr%0d", k), cyc, fin_at);
      chk($sformatf("rr%0d_rsp_valid", k), 32'(rsp_valid), 32'(oh));
      chk($sformatf("rr%0d_quo", k), rsp_quo, tq[k % 4]);
      chk($sformatf("rr%0d_rem", k), rsp_rem, tr[k % 4]);
      rsp_ready = oh;
      step();
      rsp_ready = '0;
    end
    req_valid = '0;
    step();

    // Basic operations
    do_op(0, 32'd351, 32'd23, 32'd15, 32'd6, 1'b0, 1'b0, "t1");
    do_op(1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, "t2a");
    do_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, "t2b");
    do_op(1, 32'd3, 32'd3, 32'd1, 32'd0, 1'b0, 1'b0, "t2c");

    // Backpressure: response held while others request and raise their rsp_ready
    req_a[0 +: W] = 32'd200;
    req_b[0 +: W] = 32'd9;
    req_valid = 4'b0001;
    #1;
    wait_ready("bp");
    step();
    req_valid = '0;
    wait_rsp("bp", cyc, fin_at);
    req_valid = 4'b1110;
    rsp_ready = 4'b1110;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d_quo", k), rsp_quo, 32'd22);
      chk($sformatf("bp%0d_rem", k), rsp_rem, 32'd2);
      chk($sformatf("bp%0d_no_ready", k), 32'(req_ready), 32'd0);
    end
    rsp_ready = 4'b0001;
    step();
    req_valid = '0;
    rsp_ready = '0;
    #1;
    chk("bp_rsp_drop", 32'(rsp_valid), 32'd0);

    // Reset while the divider is running
    req_a[2*W +: W] = 32'd500;
    req_b[2*W +: W] = 32'd7;
    req_valid = 4'b0100;
    #1;
    wait_ready("rw");
    step();
    req_valid = '0;
    step();
    chk("rw_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_start", 32'(div_start), 32'd0);
    chk("rw_div_a", div_a, 32'd0);
    chk("rw_div_b", div_b, 32'd0);
    chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rw_rsp_quo", rsp_quo, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    do_op(3, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, "t5");

    // Divide by zero
    do_op(2, 32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, BYP, BYP, "t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
